// File: rtl/cluster_ctrl.sv
// Cluster housekeeping: staggered per-core reset release, masked stall OR-reduction and a
// flushable miss-bus delay line. Optional stall hysteresis via `CLUSTER_STALL_HYST_EN.
module cluster_ctrl #(
  parameter int unsigned NCORE    = 36,
  parameter int unsigned SW       = 12,
  parameter int unsigned GRP_SIZE = 12,
  parameter int unsigned RST_GAP  = 4,
  parameter int unsigned HOLD     = 2,
  parameter int unsigned MW       = 36,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCORE*SW-1:0]   stall_in,
  input  logic [MW-1:0]         miss_in,
  input  logic                  miss_flush,
  output logic [NCORE-1:0]      core_rst,
  output logic                  all_up,
  output logic [SW-1:0]         stall_all,
  output logic [DEPTH*MW-1:0]   miss_tap
);

  localparam int unsigned NGRP = (NCORE + GRP_SIZE - 1) / GRP_SIZE;
  localparam int unsigned CW   = $clog2(RST_GAP + 1);
  localparam int unsigned GW   = $clog2(NGRP + 1);

  typedef enum logic [1:0] {StIdle, StRelease, StUp} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [NCORE-1:0]  core_rst_q, core_rst_d;
  logic              all_up_q, all_up_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic [SW-1:0]     raw;
  logic [DEPTH-1:0][MW-1:0] tap_q, tap_d;

  // Reset-release sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grp_d      = grp_q;
    core_rst_d = core_rst_q;
    all_up_d   = (state_q == StUp);
    unique case (state_q)
      StIdle: begin
        state_d = StRelease;
        cnt_d   = CW'(1);
      end
      StRelease: begin
        if (cnt_q == CW'(RST_GAP)) begin
          for (int i = 0; i < NCORE; i++) begin
            if (GW'(i / GRP_SIZE) == grp_q) core_rst_d[i] = 1'b0;
          end
          cnt_d = CW'(1);
          grp_d = grp_q + GW'(1);
          if (grp_q == GW'(NGRP - 1)) state_d = StUp;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StUp: begin
        state_d = StUp;
      end
      default: state_d = StIdle;
    endcase
  end

  // Cores still held in reset are masked using the currently registered core_rst.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NCORE; i++) begin
      if (!core_rst_q[i]) raw = raw | stall_in[i*SW +: SW];
    end
  end

`ifdef CLUSTER_STALL_HYST_EN
  localparam int unsigned HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  logic [SW-1:0][HW-1:0] hcnt_q, hcnt_d;

  always_comb begin
    hcnt_d  = hcnt_q;
    stall_d = '0;
    for (int b = 0; b < SW; b++) begin
      if (raw[b]) begin
        hcnt_d[b]  = HW'(HOLD);
        stall_d[b] = 1'b1;
      end else if (hcnt_q[b] != '0) begin
        hcnt_d[b]  = hcnt_q[b] - HW'(1);
        stall_d[b] = 1'b1;
      end else begin
        hcnt_d[b]  = '0;
        stall_d[b] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hcnt_q <= '0;
    else     hcnt_q <= hcnt_d;
  end
`else
  always_comb begin
    stall_d = raw;
  end
`endif

  // Flush also drops the word arriving on miss_in this cycle.
  always_comb begin
    tap_d = tap_q;
    if (miss_flush) begin
      tap_d = '0;
    end else begin
      tap_d[0] = miss_in;
      for (int k = 1; k < DEPTH; k++) tap_d[k] = tap_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      grp_q      <= '0;
      core_rst_q <= '1;
      all_up_q   <= 1'b0;
      stall_q    <= '0;
      tap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grp_q      <= grp_d;
      core_rst_q <= core_rst_d;
      all_up_q   <= all_up_d;
      stall_q    <= stall_d;
      tap_q      <= tap_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign all_up    = all_up_q;
  assign stall_all = stall_q;
  assign miss_tap  = tap_q;

endmodule

// File: tb/tb_cluster_ctrl.sv
// Scoreboard bench for cluster_ctrl: stimulus queues cycle-tagged expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_cluster_ctrl;

  localparam int NCORE = 36;
  localparam int SW    = 12;
  localparam int MW    = 36;
  localparam int DEPTH = 4;
`ifdef CLUSTER_STALL_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  localparam int KCORE = 0;
  localparam int KUP   = 1;
  localparam int KSTL  = 2;
  localparam int KTAP  = 3;

  logic                  clk;
  logic                  rst;
  logic [NCORE*SW-1:0]   stall_in;
  logic [MW-1:0]         miss_in;
  logic                  miss_flush;
  logic [NCORE-1:0]      core_rst;
  logic                  all_up;
  logic [SW-1:0]         stall_all;
  logic [DEPTH*MW-1:0]   miss_tap;

  cluster_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stall_in   (stall_in),
    .miss_in    (miss_in),
    .miss_flush (miss_flush),
    .core_rst   (core_rst),
    .all_up     (all_up),
    .stall_all  (stall_all),
    .miss_tap   (miss_tap)
  );

  typedef struct {
    int           cyc;
    int           kind;
    logic [143:0] exp;
  } chk_t;

  chk_t chk_q[$];
  int   ecnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    ecnt++;
  end

  function automatic logic [143:0] act_of(int kind);
    case (kind)
      KCORE:   return {108'b0, core_rst};
      KUP:     return {143'b0, all_up};
      KSTL:    return {132'b0, stall_all};
      default: return miss_tap;
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      KCORE:   return "core_rst";
      KUP:     return "all_up";
      KSTL:    return "stall_all";
      default: return "miss_tap";
    endcase
  endfunction

  // Monitor: compare every expectation tagged with the current edge count.
  initial forever begin
    @(negedge clk);
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc <= ecnt) begin
        logic [143:0] act;
        act = act_of(chk_q[i].kind);
        n_checks++;
        if (chk_q[i].cyc < ecnt) begin
          n_fail++;
          $display("FAIL %s stale check for edge %0d at edge %0d", kname(chk_q[i].kind),
                   chk_q[i].cyc, ecnt);
        end else if (act !== chk_q[i].exp) begin
          n_fail++;
          $display("FAIL %s edge %0d: got %h, expected %h", kname(chk_q[i].kind), ecnt, act,
                   chk_q[i].exp);
        end
        chk_q.delete(i);
      end
    end
  end

  task automatic push(input int cyc, input int kind, input logic [143:0] exp);
    chk_t c;
    c.cyc  = cyc;
    c.kind = kind;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b, x, m, r, r2;
    rst        = 1'b1;
    stall_in   = '0;
    stall_in[30*SW+5] = 1'b1;
    miss_in    = '0;
    miss_flush = 1'b0;

    // Reset state, with core 30 already stalling (reset must dominate)
    repeat (3) step();
    push(ecnt, KCORE, {108'b0, 36'hF_FFFF_FFFF});
    push(ecnt, KUP,   144'h0);
    push(ecnt, KSTL,  144'h0);
    push(ecnt, KTAP,  144'h0);

    // Staggered release; b is the first edge with rst low
    rst = 1'b0;
    b = ecnt + 1;
    push(b + 3,  KCORE, {108'b0, 36'hF_FFFF_FFFF});
    push(b + 4,  KCORE, {108'b0, 36'hF_FFFF_F000});
    push(b + 7,  KCORE, {108'b0, 36'hF_FFFF_F000});
    push(b + 8,  KCORE, {108'b0, 36'hF_FF00_0000});
    push(b + 8,  KSTL,  144'h0);
    push(b + 11, KCORE, {108'b0, 36'hF_FF00_0000});
    push(b + 12, KCORE, 144'h0);
    push(b + 12, KUP,   144'h0);
    push(b + 12, KSTL,  144'h0);
    push(b + 13, KUP,   144'h1);
    push(b + 13, KSTL,  144'h020);
    while (ecnt < b + 13) step();
    stall_in = '0;
    repeat (5) step();

    // OR across several released cores
    stall_in[0*SW+0]  = 1'b1;
    stall_in[13*SW+7] = 1'b1;
    stall_in[35*SW+11] = 1'b1;
    x = ecnt + 1;
    push(x, KSTL, 144'h881);
    step();
    stall_in = '0;
    repeat (5) step();

    // Single-cycle stall pulse: hysteresis stretches it by two cycles
    stall_in[0*SW+3] = 1'b1;
    x = ecnt + 1;
    push(x,     KSTL, 144'h008);
    push(x + 1, KSTL, HYST ? 144'h008 : 144'h0);
    push(x + 2, KSTL, HYST ? 144'h008 : 144'h0);
    push(x + 3, KSTL, 144'h0);
    step();
    stall_in = '0;
    repeat (5) step();

    // Miss delay line and flush
    m = ecnt + 1;
    push(m,     KTAP, {36'h0, 36'h0, 36'h0, 36'h1});
    push(m + 1, KTAP, {36'h0, 36'h0, 36'h1, 36'h2});
    push(m + 2, KTAP, {36'h0, 36'h1, 36'h2, 36'h3});
    push(m + 3, KTAP, {36'h1, 36'h2, 36'h3, 36'h4});
    push(m + 4, KTAP, 144'h0);
    push(m + 5, KTAP, {36'h0, 36'h0, 36'h0, 36'h5});
    push(m + 6, KTAP, {36'h0, 36'h0, 36'h5, 36'h0});
    for (int v = 1; v <= 4; v++) begin
      miss_in = MW'(v);
      step();
    end
    miss_in    = 36'hABC;
    miss_flush = 1'b1;
    step();
    miss_flush = 1'b0;
    miss_in    = 36'h5;
    step();
    miss_in = '0;
    repeat (2) step();

    // Reset from UP with stall and miss traffic present
    stall_in[0*SW+0] = 1'b1;
    miss_in = 36'h7;
    step();
    rst = 1'b1;
    r = ecnt + 1;
    push(r,     KCORE, {108'b0, 36'hF_FFFF_FFFF});
    push(r,     KUP,   144'h0);
    push(r,     KSTL,  144'h0);
    push(r,     KTAP,  144'h0);
    push(r + 1, KTAP,  {36'h0, 36'h0, 36'h0, 36'h7});
    push(r + 1, KSTL,  144'h0);
    push(r + 2, KUP,   144'h0);
    push(r + 4, KCORE, {108'b0, 36'hF_FFFF_FFFF});
    push(r + 5, KCORE, {108'b0, 36'hF_FFFF_F000});
    push(r + 5, KSTL,  144'h0);
    push(r + 6, KSTL,  144'h001);
    push(r + 9, KCORE, {108'b0, 36'hF_FF00_0000});
    step();
    rst = 1'b0;
    while (ecnt < r + 9) step();

    // Reset mid-sequence after groups 0 and 1 are released
    rst = 1'b1;
    r2 = ecnt + 1;
    push(r2,      KCORE, {108'b0, 36'hF_FFFF_FFFF});
    push(r2,      KUP,   144'h0);
    push(r2 + 4,  KCORE, {108'b0, 36'hF_FFFF_FFFF});
    push(r2 + 5,  KCORE, {108'b0, 36'hF_FFFF_F000});
    push(r2 + 13, KCORE, 144'h0);
    push(r2 + 13, KUP,   144'h0);
    push(r2 + 14, KUP,   144'h1);
    step();
    rst = 1'b0;

    for (int t = 0; t < 50 && chk_q.size() > 0; t++) step();
    if (chk_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending, expected 0", chk_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
